// File: rtl/cache_miss_controller.sv
// Miss controller for the direct-mapped data cache: tag lookup, block fetch with
// optional timeout, line fill and read, plus saturating hit/miss/access statistics.
module cache_miss_controller #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned OFFSET_W    = 2,
    parameter int unsigned COUNT_W     = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               req,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               hit,
    output logic [ADDR_W-1:0]  lookup_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_valid,
    output logic               ready,
    output logic               cache_write,
    output logic               cache_read,
    output logic               done,
    output logic               err,
    input  logic               stat_clear,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count,
    output logic [COUNT_W-1:0] acc_count
);

    localparam int unsigned TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMemWait,
        StFill,
        StRead,
        StAbort
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [TO_W-1:0]   to_q, to_d;
    logic              timed_out;

    // Zero timeout means wait for the memory forever.
    assign timed_out = (MEM_TIMEOUT != 0) && (to_q == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        unique case (state_q)
            StIdle:   if (req) state_d = StLookup;
            StLookup: begin
                if (hit) begin
                    state_d = StRead;
                end else begin
                    state_d = StMemWait;
                    to_d    = '0;
                end
            end
            StMemWait: begin
                to_d = to_q + 1'b1;
                if (mem_valid)      state_d = StFill;
                else if (timed_out) state_d = StAbort;
            end
            StFill:   state_d = StRead;
            StRead:   state_d = StIdle;
            StAbort:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            if (state_q == StIdle && req) addr_q <= addr;
        end
    end

    always_comb begin
        ready       = 1'b0;
        mem_req     = 1'b0;
        cache_write = 1'b0;
        cache_read  = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (state_q)
            StIdle:    ready = 1'b1;
            StMemWait: mem_req = 1'b1;
            StFill:    cache_write = 1'b1;
            StRead: begin
                cache_read = 1'b1;
                done       = 1'b1;
            end
            StAbort: begin
                err  = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign lookup_addr = addr_q;
    assign mem_addr    = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

    // Counters saturate at all-ones; stat_clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            acc_count  <= '0;
        end else if (stat_clear) begin
            hit_count  <= '0;
            miss_count <= '0;
            acc_count  <= '0;
        end else begin
            if (state_q == StLookup && hit && !(&hit_count)) hit_count <= hit_count + 1'b1;
            if (state_q == StLookup && !hit && !(&miss_count)) miss_count <= miss_count + 1'b1;
            if (state_q == StRead && !(&acc_count)) acc_count <= acc_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_miss_controller.sv
// Randomized bench for cache_miss_controller against a transaction-level model of
// the access sequence and saturating statistics.
module tb_cache_miss_controller;

    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned TIMEOUT = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [5:0] S_IDLE  = 6'b100000;
    localparam logic [5:0] S_LOOK  = 6'b000000;
    localparam logic [5:0] S_WAIT  = 6'b010000;
    localparam logic [5:0] S_FILL  = 6'b001000;
    localparam logic [5:0] S_READ  = 6'b000110;
    localparam logic [5:0] S_ABORT = 6'b000011;

    logic              clk = 1'b0;
    logic              clear_n = 1'b0;
    logic              req = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              hit = 1'b0;
    logic [ADDR_W-1:0] lookup_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid = 1'b0;
    logic              ready, cache_write, cache_read, done, err;
    logic              stat_clear = 1'b0;
    logic [CNT_W-1:0]  hit_count, miss_count, acc_count;
    logic [5:0]        obs;

    int checks = 0;
    int errors = 0;
    int m_hit = 0, m_miss = 0, m_acc = 0;

    cache_miss_controller #(
        .ADDR_W     (ADDR_W),
        .OFFSET_W   (OFF_W),
        .COUNT_W    (CNT_W),
        .MEM_TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .req        (req),
        .addr       (addr),
        .hit        (hit),
        .lookup_addr(lookup_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .ready      (ready),
        .cache_write(cache_write),
        .cache_read (cache_read),
        .done       (done),
        .err        (err),
        .stat_clear (stat_clear),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .acc_count  (acc_count)
    );

    always #5 clk = ~clk;

    assign obs = {ready, mem_req, cache_write, cache_read, done, err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : CNT_MAX;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_strobes"}, 32'(obs), 32'(S_IDLE));
        check({tag, "_hits"}, 32'(hit_count), 32'(m_hit));
        check({tag, "_misses"}, 32'(miss_count), 32'(m_miss));
        check({tag, "_accs"}, 32'(acc_count), 32'(m_acc));
    endtask

    // One access starting at a negedge in IDLE. k = wait cycle in which mem_valid
    // arrives (k > TIMEOUT means the memory never answers in time).
    task automatic access(input logic [ADDR_W-1:0] a, input bit h, input int k, input bit clr);
        logic [ADDR_W-1:0] blk;
        blk = a;
        blk[OFF_W-1:0] = '0;
        req  = 1'b1;
        addr = a;
        @(negedge clk);
        check("lookup_strobes", 32'(obs), 32'(S_LOOK));
        check("lookup_addr", 32'(lookup_addr), 32'(a));
        req        = 1'($urandom_range(0, 1));
        addr       = ADDR_W'($urandom);
        hit        = h;
        mem_valid  = 1'($urandom_range(0, 1));
        stat_clear = clr;
        if (clr) begin
            m_hit = 0; m_miss = 0; m_acc = 0;
        end else if (h) begin
            m_hit = sat_inc(m_hit);
        end else begin
            m_miss = sat_inc(m_miss);
        end
        @(negedge clk);
        stat_clear = 1'b0;
        if (h) begin
            check("hit_read", 32'(obs), 32'(S_READ));
            m_acc = sat_inc(m_acc);
        end else begin
            for (int i = 1; i <= TIMEOUT; i++) begin
                check("wait_strobes", 32'(obs), 32'(S_WAIT));
                check("mem_addr", 32'(mem_addr), 32'(blk));
                mem_valid = (i == k);
                hit       = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (i == k) break;
            end
            mem_valid = 1'($urandom_range(0, 1));
            if (k <= TIMEOUT) begin
                check("fill_strobes", 32'(obs), 32'(S_FILL));
                @(negedge clk);
                check("miss_read", 32'(obs), 32'(S_READ));
                m_acc = sat_inc(m_acc);
            end else begin
                check("abort_strobes", 32'(obs), 32'(S_ABORT));
            end
        end
        req       = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        check_idle("after");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_idle("reset");
        clear_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        access(15'h0123, 1'b1, 0, 1'b0);
        access(15'h0127, 1'b0, 4, 1'b0);
        access(15'h0200, 1'b0, 100, 1'b0);
        for (int i = 0; i < 5; i++) access(ADDR_W'($urandom), 1'b1, 0, 1'b0);
        access(15'h0040, 1'b1, 0, 1'b1);

        // Asynchronous reset in the middle of a memory wait.
        req  = 1'b1;
        addr = 15'h1234;
        @(negedge clk);
        req = 1'b0;
        hit = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_wait", 32'(obs), 32'(S_WAIT));
        #2 clear_n = 1'b0;
        #1;
        m_hit = 0; m_miss = 0; m_acc = 0;
        check_idle("mid_reset");
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check_idle("released");
        access(15'h0555, 1'b0, 2, 1'b0);

        for (int n = 0; n < 200; n++) begin
            int idle_n;
            idle_n = $urandom_range(0, 2);
            for (int j = 0; j < idle_n; j++) begin
                mem_valid = 1'($urandom_range(0, 1));
                hit       = 1'($urandom_range(0, 1));
                @(negedge clk);
                check_idle("idle");
            end
            mem_valid = 1'($urandom_range(0, 1));
            access(ADDR_W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 6),
                   ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
